instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder and program loader. It accepts symbolic instruction requests (mnemonic plus register, immediate and target fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. Encoded words are buffered in a small FIFO and written to consecutive instruction-memory addresses through a req/ack write port. It is the producer side of the instruction stream that the control-unit decoder consumes, and is used by test harnesses and the boot loader to build programs in instruction memory.

## Interface
- `DEPTH`, 4: encoded-word FIFO depth; must be a power of two and at least 2.
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first write address after reset or flush.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous restart of the program load.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  4  mnemonic: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 ADDI, 11 ANDI, 12 ORI, 13 SLTI, 14 J, 15 illegal.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  immediate or branch offset.
- `in_target`  in  26  jump target.
- `imem_req`  out  1  write request.
- `imem_ack`  in  1  write accepted; may be asserted in the same cycle as `imem_req`.
- `imem_addr`  out  ADDR_W  write word address.
- `imem_wdata`  out  32  encoded word.
- `err_illegal`  out  1  one-cycle pulse when an illegal op is accepted.
- `prog_full`  out  1  sticky flag: the last address has been written.
- `busy`  out  1  FIFO non-empty or a write is pending.

## Operation
- **Encoding.** Encoding is combinational at the input; the word is pushed into the FIFO on a handshake.
  - R-type words are `{6'h00, rs, rt, rd, 5'h00, funct}` with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type words are `{opcode, rs, rt, imm}` with opcode LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, SLTI 0x0A.
  - J words are `{6'h02, target}`.
  - NOP is 32'h0.
  - Fields an op does not use are ignored and their bit positions are forced to zero.
- **Illegal op (15).** The request is consumed (handshake completes) but nothing is pushed; `err_illegal` pulses in the next cycle.
- **Input readiness.** `in_ready = !fifo_full & !prog_full & !flush & !reset`.
- **Write FSM.**
  - IDLE: if the FIFO is non-empty and `prog_full` is 0, latch the FIFO head into `imem_wdata` and go to WRITE.
  - WRITE: `imem_req = 1`; `imem_addr` and `imem_wdata` are held stable until ack. On `imem_ack`: pop the FIFO, increment `imem_addr` (wraps modulo 2^ADDR_W), return to IDLE.
  - If the acked address was 2^ADDR_W-1, set `prog_full`. Remaining FIFO entries are then held unwritten until flush or reset.
- **Flush.** Flush empties the FIFO, sets `imem_addr` to BASE_ADDR, clears `prog_full` and forces IDLE. Flush wins over a same-cycle `imem_ack`: no pop, no increment, and that write is treated as aborted.
- **busy** is `(state == WRITE) | !fifo_empty`.
- **Simultaneous push and pop** in the same cycle is allowed, including when the FIFO is full (`in_ready` is still low in that case).

## Timing
- **Reset values:** `imem_req` 0, `imem_addr` BASE_ADDR, `imem_wdata` 0, `err_illegal` 0, `prog_full` 0, `busy` 0, FSM in IDLE. `in_ready` is 0 during the reset cycle and 1 in the cycle after.
- **Latency.**
  - A handshake in cycle t puts `imem_req` high in cycle t+2.
  - With ack in cycle t+2, the next word's request is earliest in cycle t+4.
  - Sustained throughput is one word per 2 cycles plus ack wait.
- **Reset or flush mid-write:** `imem_req` is low in the following cycle, and the partial transaction is dropped.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J);
  - funct constants;
  - mnemonic enum `mnem_t` (4 bits);
  - these are also used by the control-unit decoder.
- Sub-module `sync_fifo` (parameters WIDTH=32, DEPTH) with push/pop/full/empty.
- The encoder mux and the write FSM live in `instr_encoder`.

## Test plan
- **Encoding.** Each case is pushed with `imem_ack` tied high and checked at `imem_wdata`/`imem_addr`.
  - ADD rd=3, rs=1, rt=2 → 32'h00221820 at address 0.
  - LW rt=8, rs=29, imm=0x0004 → 32'h8FA80004.
  - BEQ rs=1, rt=2, imm=0xFFFF → 32'h1022FFFF.
  - J target=0x10 → 32'h08000010.
  - The four words land at consecutive addresses 0..3.
- **Backpressure.** Hold `imem_ack` low and push 6 requests → exactly DEPTH=4 accepted, after which `in_ready` goes low. `imem_req`, `imem_addr` and `imem_wdata` stay stable. Releasing ack drains the words in order.
- **Illegal op.** Push op=15 → `err_illegal` high for exactly 1 cycle, no `imem_req`, `imem_addr` unchanged.
- **Full program.** With ADDR_W=2, push 5 ADDIs → 4 writes to addresses 0..3, then `prog_full`=1, `in_ready`=0, and the 5th word is not written. Flush → `prog_full`=0 and the next write goes to address 0.
- **Flush/reset mid-write.** Assert flush together with `imem_ack` in WRITE → no pop, `imem_addr`=BASE_ADDR and `imem_req`=0 next cycle, FIFO empty. Repeat with reset → all reset values hold.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, R-type funct codes and the
// 4-bit mnemonic set used by both this encoder and the control-unit decoder.
package mips_pkg;

  // Symbolic instruction mnemonics carried on the request interface
  typedef enum logic [3:0] {
    MN_NOP     = 4'd0,
    MN_ADD     = 4'd1,
    MN_SUB     = 4'd2,
    MN_AND     = 4'd3,
    MN_OR      = 4'd4,
    MN_SLT     = 4'd5,
    MN_LW      = 4'd6,
    MN_SW      = 4'd7,
    MN_BEQ     = 4'd8,
    MN_BNE     = 4'd9,
    MN_ADDI    = 4'd10,
    MN_ANDI    = 4'd11,
    MN_ORI     = 4'd12,
    MN_SLTI    = 4'd13,
    MN_J       = 4'd14,
    MN_ILLEGAL = 4'd15
  } mnem_t;

  // Primary opcode field, bits [31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_J     = 6'h02;

  // R-type function field, bits [5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and clear. Push while full is
// accepted only together with a pop; the head is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_pop  = pop & !empty;
  assign w_push = push & (!full | w_pop);
  assign head   = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; clear behaves like reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; occupancy is tracked by
    // the pointers, so stale contents are never observed and the array can map
    // onto plain RAM/flops without a reset network.
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder and program loader: encodes symbolic
// requests into 32-bit words, buffers them, and writes them to consecutive
// instruction-memory addresses over a req/ack port.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              prog_full,
  output logic              busy
);

  typedef enum logic {WR_IDLE, WR_WRITE} wr_state_t;

  wr_state_t         r_state;
  wr_state_t         w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_prog_full;
  logic              r_err_illegal;

  mnem_t             w_op;
  logic [31:0]       w_enc_word;
  logic              w_illegal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic [31:0]       w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_op     = mnem_t'(in_op);
  assign in_ready = !w_fifo_full & !r_prog_full & !flush & !reset;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & !w_illegal;

  // Combinational encoder: unused fields are never routed, so their bits stay zero
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_enc_word = 32'h0;
    w_illegal  = 1'b0;
    case (w_op)
      MN_NOP:  w_enc_word = 32'h0;
      MN_ADD:  w_enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_ADD};
      MN_SUB:  w_enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_SUB};
      MN_AND:  w_enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_AND};
      MN_OR:   w_enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_OR};
      MN_SLT:  w_enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_SLT};
      MN_LW:   w_enc_word = {OPC_LW,   in_rs, in_rt, in_imm};
      MN_SW:   w_enc_word = {OPC_SW,   in_rs, in_rt, in_imm};
      MN_BEQ:  w_enc_word = {OPC_BEQ,  in_rs, in_rt, in_imm};
      MN_BNE:  w_enc_word = {OPC_BNE,  in_rs, in_rt, in_imm};
      MN_ADDI: w_enc_word = {OPC_ADDI, in_rs, in_rt, in_imm};
      MN_ANDI: w_enc_word = {OPC_ANDI, in_rs, in_rt, in_imm};
      MN_ORI:  w_enc_word = {OPC_ORI,  in_rs, in_rt, in_imm};
      MN_SLTI: w_enc_word = {OPC_SLTI, in_rs, in_rt, in_imm};
      MN_J:    w_enc_word = {OPC_J, in_target};
      default: w_illegal  = 1'b1;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (w_push),
    .push_data (w_enc_word),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Write FSM next-state: load head in IDLE, pop on ack in WRITE; flush aborts all
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      WR_IDLE: begin
        if (!w_fifo_empty && !r_prog_full) begin
          w_load       = 1'b1;
          w_next_state = WR_WRITE;
        end
      end
      WR_WRITE: begin
        if (imem_ack) begin
          w_pop        = 1'b1;
          w_next_state = WR_IDLE;
        end
      end
      default: w_next_state = WR_IDLE;
    endcase
    if (flush) begin
      w_next_state = WR_IDLE;
      w_load       = 1'b0;
      w_pop        = 1'b0;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WR_IDLE;
    else       r_state <= w_next_state;
  end

  // Write address, data latch and sticky program-full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= BASE_ADDR;
      r_wdata     <= 32'h0;
      r_prog_full <= 1'b0;
    end else if (flush) begin
      r_addr      <= BASE_ADDR;
      r_prog_full <= 1'b0;
    end else begin
      if (w_load) r_wdata <= w_fifo_head;
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_addr == {ADDR_W{1'b1}}) r_prog_full <= 1'b1;
      end
    end
  end

  // One-cycle pulse for an accepted illegal request
  always_ff @(posedge clk) begin
    if (reset) r_err_illegal <= 1'b0;
    else       r_err_illegal <= w_accept & w_illegal;
  end

  assign imem_req    = (r_state == WR_WRITE);
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign err_illegal = r_err_illegal;
  assign prog_full   = r_prog_full;
  assign busy        = (r_state == WR_WRITE) | !w_fifo_empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a write scoreboard: expected
// {address, word} pairs are queued on each accepted request and compared
// when the DUT completes an imem write.
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_req;
  logic              imem_ack;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              prog_full;
  logic              busy;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (2'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .err_illegal (err_illegal),
    .prog_full   (prog_full),
    .busy        (busy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [ADDR_W-1:0] exp_addr = '0;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoding built from the instruction-format tables
  function automatic logic [31:0] model(input logic [3:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      4'd1:  w = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd2:  w = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd3:  w = {6'h00, rs, rt, rd, 5'h00, 6'h24};
      4'd4:  w = {6'h00, rs, rt, rd, 5'h00, 6'h25};
      4'd5:  w = {6'h00, rs, rt, rd, 5'h00, 6'h2A};
      4'd6:  w = {6'h23, rs, rt, imm};
      4'd7:  w = {6'h2B, rs, rt, imm};
      4'd8:  w = {6'h04, rs, rt, imm};
      4'd9:  w = {6'h05, rs, rt, imm};
      4'd10: w = {6'h08, rs, rt, imm};
      4'd11: w = {6'h0C, rs, rt, imm};
      4'd12: w = {6'h0D, rs, rt, imm};
      4'd13: w = {6'h0A, rs, rt, imm};
      4'd14: w = {6'h02, tgt};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Write monitor: every completed write must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && flush !== 1'b1 && imem_req === 1'b1 && imem_ack === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {31'b0, imem_req}, 32'b0);
        end else begin
          mon_e = sb.pop_front();
          check("wr_addr", {30'b0, imem_addr}, {30'b0, mon_e.addr});
          check("wr_data", imem_wdata, mon_e.data);
        end
      end
    end
  end

  // Offer one request for up to budget cycles; queue its expected write on accept
  task automatic try_send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic [31:0] exp_word, input int budget, output bit accepted);
    exp_t e;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_valid  = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        accepted = 1'b1;
        if (op != 4'd15) begin
          e.addr = exp_addr;
          e.data = exp_word;
          sb.push_back(e);
          exp_addr = exp_addr + 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] exp_word);
    bit acc;
    try_send(op, rs, rt, rd, imm, tgt, exp_word, 20, acc);
    check("send_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_m(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    send(op, rs, rt, rd, imm, tgt, model(op, rs, rt, rd, imm, tgt));
  endtask

  // Wait (bounded) until the scoreboard holds n entries
  task automatic wait_sb(input int n, input int budget);
    for (int i = 0; i < budget && sb.size() != n; i++) begin
      @(posedge clk);
      #1;
    end
    check("sb_level", sb.size(), n);
  endtask

  task automatic wait_req(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) seen = 1'b1;
    end
    check("req_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    sb.delete();
    exp_addr = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},       {31'b0, imem_req},    32'd0);
    check({tag, "_addr"},      {30'b0, imem_addr},   32'd0);
    check({tag, "_wdata"},     imem_wdata,           32'd0);
    check({tag, "_err"},       {31'b0, err_illegal}, 32'd0);
    check({tag, "_prog_full"}, {31'b0, prog_full},   32'd0);
    check({tag, "_busy"},      {31'b0, busy},        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Encoding with ack tied high; unused fields carry junk
    imem_ack = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FFFFFF, 32'h00221820);
    @(negedge clk);
    check("lat_t1_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("lat_t2_req", {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1;
    send(4'd6, 5'd29, 5'd8, 5'd7, 16'h0004, 26'h155, 32'h8FA80004);
    send(4'd8, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AAAAAA, 32'h1022FFFF);
    send(4'd14, 5'd9, 5'd10, 5'd11, 16'h1234, 26'h0000010, 32'h08000010);
    wait_sb(0, 60);
    @(negedge clk);
    check("enc_prog_full", {31'b0, prog_full}, 32'd1);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    check("enc_flush_prog_full", {31'b0, prog_full}, 32'd0);
    @(posedge clk); #1;
    send(4'd2, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h3FFFFFF, 32'h00853022);
    send(4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000);
    send(4'd7, 5'd2, 5'd3, 5'd17, 16'h1234, 26'h3FFFFFF, 32'hAC431234);
    send(4'd12, 5'd0, 5'd31, 5'd5, 16'hABCD, 26'h1, 32'h341FABCD);
    wait_sb(0, 60);
    do_flush();

    // Illegal op: consumed, one-cycle error pulse, nothing written
    send(4'd15, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 32'h0);
    @(negedge clk);
    check("ill_err_pulse", {31'b0, err_illegal}, 32'd1);
    @(negedge clk);
    check("ill_err_clear", {31'b0, err_illegal}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ill_no_req", {31'b0, imem_req}, 32'd0);
    end
    check("ill_addr", {30'b0, imem_addr}, 32'd0);
    check("ill_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: ack low, offer 6 requests, exactly DEPTH accepted
    imem_ack = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(4'd10, 5'(i), 5'(i + 8), 5'd0, 16'h0100 + 16'(i), 26'h0,
               model(4'd10, 5'(i), 5'(i + 8), 5'd0, 16'h0100 + 16'(i), 26'h0), 3, acc);
      if (acc) n_acc++;
    end
    check("bp_accepted", n_acc, DEPTH);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_req_hold", {31'b0, imem_req}, 32'd1);
      check("bp_addr_hold", {30'b0, imem_addr}, {30'b0, sb[0].addr});
      check("bp_wdata_hold", imem_wdata, sb[0].data);
    end
    @(posedge clk); #1;
    imem_ack = 1'b1;
    wait_sb(0, 60);
    do_flush();

    // Full program: 5 ADDIs, only 4 written, then sticky prog_full
    for (int i = 0; i < 5; i++) begin
      send_m(4'd10, 5'(i + 1), 5'(i + 2), 5'd0, 16'h7000 + 16'(i), 26'h0);
    end
    wait_sb(1, 60);
    @(negedge clk);
    check("fp_prog_full", {31'b0, prog_full}, 32'd1);
    check("fp_in_ready", {31'b0, in_ready}, 32'd0);
    check("fp_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fp_no_req", {31'b0, imem_req}, 32'd0);
    end
    check("fp_unwritten", sb.size(), 1);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    check("fp_flush_prog_full", {31'b0, prog_full}, 32'd0);
    check("fp_flush_busy", {31'b0, busy}, 32'd0);
    check("fp_flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_m(4'd11, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0);
    wait_sb(0, 30);
    do_flush();

    // Flush together with ack while in WRITE
    send_m(4'd13, 5'd6, 5'd7, 5'd0, 16'h8000, 26'h0);
    wait_sb(0, 30);
    imem_ack = 1'b0;
    send_m(4'd9, 5'd8, 5'd9, 5'd0, 16'h0010, 26'h0);
    wait_req(10);
    check("fm_addr_before", {30'b0, imem_addr}, 32'd1);
    flush = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; imem_ack = 1'b0;
    sb.delete(); exp_addr = '0;
    @(negedge clk);
    check("fm_req", {31'b0, imem_req}, 32'd0);
    check("fm_addr", {30'b0, imem_addr}, 32'd0);
    check("fm_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset together with ack while in WRITE
    send_m(4'd3, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0);
    wait_sb(0, 30);
    imem_ack = 1'b0;
    send_m(4'd4, 5'd13, 5'd14, 5'd15, 16'h0, 26'h0);
    wait_req(10);
    check("rm_addr_before", {30'b0, imem_addr}, 32'd1);
    reset = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    check("rm_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; imem_ack = 1'b0;
    sb.delete(); exp_addr = '0;
    @(negedge clk);
    check_reset_vals("rm");
    check("rm_in_ready_after", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    imem_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
